ooo_reservation_station: RTL and testbench
==========================================

Name: ooo_reservation_station

Overview:
- Out-of-order successor to the in-order FIFO reservation station; sits between rename/dispatch and the functional units.
- Holds DEPTH entries in any free slot, wakes operands from SEARCH_PORTS result broadcasts, and issues up to OUTPUT_PORTS fully-ready entries per cycle, oldest first.
- Replaces whole-queue flush with selective branch-mask kill, so non-speculative entries survive a mispredict.

Parameters:
- INPUT_PORTS, 2, dispatch lanes per cycle.
- OUTPUT_PORTS, 2, issue lanes per cycle.
- SEARCH_PORTS, 4, wakeup broadcast buses.
- ROB_DEPTH, 16, tag space; tag width $clog2(ROB_DEPTH).
- OPERAND_WIDTH, 32, operand data width.
- DEPTH, 8, entries; must be at least INPUT_PORTS and at least OUTPUT_PORTS.
- EXTRA_DATA_WIDTH, 4, opaque sideband carried with each entry.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ready_out  out  INPUT_PORTS  lane i may push.
- valid_in  in  INPUT_PORTS  push request per lane.
- data_in  in  INPUT_PORTS x reservation_entry_t  entries being pushed.
- extra_in  in  INPUT_PORTS x EXTRA_DATA_WIDTH  sideband being pushed.
- valid_out  out  OUTPUT_PORTS  issue lane j carries a ready entry.
- ready_in  in  OUTPUT_PORTS  functional unit accepts lane j.
- data_out  out  OUTPUT_PORTS x reservation_entry_t  issued entries.
- extra_out  out  OUTPUT_PORTS x EXTRA_DATA_WIDTH  issued sideband.
- search_valid  in  SEARCH_PORTS  broadcast valid.
- search_tags  in  SEARCH_PORTS x $clog2(ROB_DEPTH)  broadcast tag.
- search_data  in  SEARCH_PORTS x OPERAND_WIDTH  broadcast value.
- branch_resolved  in  1  oldest branch resolved correctly; shift all masks right by 1.
- flush  in  1  oldest branch mispredicted.

Behaviour:
- Reset (rst_n=0, async):
  - all entry valid bits 0 and the age matrix cleared.
  - Outputs: valid_out=0, ready_out=all 1 (DEPTH >= INPUT_PORTS), data_out=0, extra_out=0.
  - Reset asserted mid-operation discards everything on the next evaluation, with no partial pushes.
- Push:
  - free = DEPTH - occupied, using registered state only.
  - ready_out[i] = (free > i) & ~flush. Slots freed by this cycle's issue are not reusable until the next cycle.
  - Lanes are packed: lane i writes the i-th lowest-index free slot among accepted lanes.
  - A push with valid_in & ~ready_out is ignored.
- Same-cycle capture: an incoming operand whose tag matches a valid broadcast in the push cycle is stored with its value and pending cleared. The match must use data_in pending bits, never the target slot's stale contents.
- Wakeup: each stored valid entry with pendingX=1 and a tag match on any valid search port latches the data and clears pendingX. Applies to A, B and C. If several ports match, the lowest port index wins.
- Ready: an entry is ready when it is valid and pendingA, pendingB and pendingC are all 0, taken from registered state. Broadcast-to-issue latency is therefore 1 cycle; a push is issuable at the earliest 1 cycle after the push.
- Select:
  - The age matrix picks the OUTPUT_PORTS oldest ready entries.
  - Lane 0 carries the oldest, lane 1 the next, and so on.
  - Unfilled lanes have valid_out=0 and data_out=0.
  - Outputs are combinational from registered state; no same-cycle input reaches valid_out.
- Issue handshake:
  - An entry leaves on valid_out[j] & ready_in[j].
  - If ready_in[j]=0 the entry stays and may be presented on another lane next cycle.
  - ready_in may depend on valid_out.
- Age matrix: on push, the new row is marked younger than every existing valid entry. Among lanes pushed in the same cycle, lower lane index is older.
- branch_resolved: every valid entry's branch_if is shifted right by 1, including entries pushed this cycle.
- flush:
  - Entries with branch_if[0]=1 are invalidated; their valid_out is forced 0 in the flush cycle, so they are never issued.
  - Entries with branch_if[0]=0 survive, and their issue handshakes in the flush cycle complete normally.
  - Pushes in the flush cycle are dropped (ready_out=0).
- flush with branch_resolved in the same cycle: the kill test uses the pre-shift mask, then survivors are shifted.
- Full: ready_out is all 0 with DEPTH valid entries. Empty: valid_out is all 0.
- Simultaneous push and issue in one cycle are legal. Occupancy(t+1) = occupancy(t) + pushes - issues - kills.

Decomposition:
- Shared package (structs.sv): reservation_entry_t with fields opA/B/C, tagA/B/C, pendingA/B/C and branch_if, unchanged from the existing entry type.
- Also in the shared package: a function computing the tag width from ROB_DEPTH.
- Sub-module rs_age_matrix:
  - DEPTH x DEPTH older-than bits.
  - Inputs: alloc one-hot per lane, dealloc vector, request (ready) vector.
  - Output: OUTPUT_PORTS one-hot grants ordered by age.
  - Shares clk and rst_n with the parent.

Test Plan:
- Push 2 entries with all pending=0; ready_in=11 -> both issue the next cycle, lane0 = first pushed, occupancy returns to 0.
- Push entry with tagA=5 pending; broadcast tag 5, data 0xDEADBEEF two cycles later -> valid_out rises 1 cycle after the broadcast with opA=0xDEADBEEF.
- Push with tagB=3 pending while search_tags[2]=3 is valid in the same cycle -> entry stored with pendingB=0 and the broadcast value; issuable the next cycle.
- Fill 8 entries -> ready_out=00; issue 1 entry -> ready_out=01 the following cycle, not earlier.
- Entries with branch_if 0001, 0010 and 0000 present; assert flush -> the 0001 entry is killed and never appears on valid_out; the others survive.
- Assert branch_resolved then flush -> the 0010 entry (now 0001) is killed.
- Younger entry becomes ready before an older one -> younger issues first; when both are ready, the older takes lane 0.
- Hold ready_in=0 for 3 cycles -> valid_out and data_out are stable; deassert rst_n mid-stream -> valid_out=0 and ready_out=11 immediately.

Source files
------------

// File: rtl/ooo_reservation_station_pkg.sv
// Shared types for the out-of-order reservation station.
// Provides the reservation entry layout, the tag width helper and the
// default widths that the entry type is built from.
package ooo_reservation_station_pkg;

    // Tag width needed to name every ROB slot (never less than one bit).
    function automatic int tag_width(input int rob_depth);
        return (rob_depth > 1) ? $clog2(rob_depth) : 1;
    endfunction

    localparam int RS_ROB_DEPTH = 16;
    localparam int RS_TAG_W     = tag_width(RS_ROB_DEPTH);
    localparam int RS_OPERAND_W = 32;
    localparam int RS_BRANCH_W  = 4;

    typedef struct packed {
        logic [RS_OPERAND_W-1:0] opA;
        logic [RS_OPERAND_W-1:0] opB;
        logic [RS_OPERAND_W-1:0] opC;
        logic [RS_TAG_W-1:0]     tagA;
        logic [RS_TAG_W-1:0]     tagB;
        logic [RS_TAG_W-1:0]     tagC;
        logic                    pendingA;
        logic                    pendingB;
        logic                    pendingC;
        logic [RS_BRANCH_W-1:0]  branch_if;
    } reservation_entry_t;

endpackage

// File: rtl/ooo_reservation_station_if.sv
// Bundle of dispatch, issue, wakeup and branch signals around the
// reservation station.
//   master: dispatch/FU/broadcast side (drives pushes, ready_in, search, branch)
//   slave : the reservation station itself
interface ooo_reservation_station_if
    import ooo_reservation_station_pkg::*;
#(
    parameter int INPUT_PORTS      = 2,
    parameter int OUTPUT_PORTS     = 2,
    parameter int SEARCH_PORTS     = 4,
    parameter int EXTRA_DATA_WIDTH = 4
);
    logic [INPUT_PORTS-1:0]                        ready_out;
    logic [INPUT_PORTS-1:0]                        valid_in;
    reservation_entry_t [INPUT_PORTS-1:0]          data_in;
    logic [INPUT_PORTS-1:0][EXTRA_DATA_WIDTH-1:0]  extra_in;

    logic [OUTPUT_PORTS-1:0]                       valid_out;
    logic [OUTPUT_PORTS-1:0]                       ready_in;
    reservation_entry_t [OUTPUT_PORTS-1:0]         data_out;
    logic [OUTPUT_PORTS-1:0][EXTRA_DATA_WIDTH-1:0] extra_out;

    logic [SEARCH_PORTS-1:0]                       search_valid;
    logic [SEARCH_PORTS-1:0][RS_TAG_W-1:0]         search_tags;
    logic [SEARCH_PORTS-1:0][RS_OPERAND_W-1:0]     search_data;

    logic                                          branch_resolved;
    logic                                          flush;

    modport master (
        input  ready_out, valid_out, data_out, extra_out,
        output valid_in, data_in, extra_in, ready_in,
        output search_valid, search_tags, search_data,
        output branch_resolved, flush
    );

    modport slave (
        output ready_out, valid_out, data_out, extra_out,
        input  valid_in, data_in, extra_in, ready_in,
        input  search_valid, search_tags, search_data,
        input  branch_resolved, flush
    );

endinterface

// File: rtl/rs_age_matrix.sv
// Age matrix for the reservation station: tracks relative age of all slots
// and grants the OUTPUT_PORTS oldest requesting slots, oldest on grant[0].
//   clk, rst_n : clock and asynchronous active-low reset
//   alloc      : per dispatch lane, one-hot slot being written this cycle
//   dealloc    : slots leaving this cycle (issued or killed)
//   req        : slots eligible for issue
//   grant      : per issue lane, one-hot slot selected (zero if none)
module rs_age_matrix #(
    parameter int DEPTH        = 8,
    parameter int INPUT_PORTS  = 2,
    parameter int OUTPUT_PORTS = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [INPUT_PORTS-1:0][DEPTH-1:0]      alloc,
    input  logic [DEPTH-1:0]                       dealloc,
    input  logic [DEPTH-1:0]                       req,
    output logic [OUTPUT_PORTS-1:0][DEPTH-1:0]     grant
);
    localparam int RANK_W = $clog2(DEPTH) + 1;

    // older_q[r][c] = 1 means slot r is older than slot c.
    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
    logic [DEPTH-1:0][RANK_W-1:0] rank;

    always_comb begin
        older_d = older_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (dealloc[r]) begin
                older_d[r] = '0;
                for (int c = 0; c < DEPTH; c++) older_d[c][r] = 1'b0;
            end
        end
        // Lanes are applied in order so a later lane ends up younger than an
        // earlier one: its cleared row overrides the column bit set before.
        for (int i = 0; i < INPUT_PORTS; i++) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (alloc[i][r]) begin
                    older_d[r] = '0;
                    for (int c = 0; c < DEPTH; c++) begin
                        if (c != r) older_d[c][r] = 1'b1;
                    end
                end
            end
        end
    end

    // Rank = number of older requesters; valid slots form a total order, so
    // ranks among requesters are unique and rank j goes to issue lane j.
    always_comb begin
        grant = '0;
        for (int r = 0; r < DEPTH; r++) begin
            rank[r] = '0;
            for (int c = 0; c < DEPTH; c++) begin
                if (req[c] && older_q[c][r]) rank[r] = rank[r] + RANK_W'(1);
            end
        end
        for (int j = 0; j < OUTPUT_PORTS; j++) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (req[r] && rank[r] == RANK_W'(j)) grant[j][r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) older_q <= '0;
        else        older_q <= older_d;
    end

endmodule

// File: rtl/ooo_reservation_station.sv
// Out-of-order reservation station. Accepts up to INPUT_PORTS entries per
// cycle into any free slot, wakes pending operands from SEARCH_PORTS result
// broadcasts, and issues up to OUTPUT_PORTS fully ready entries per cycle,
// oldest first. A mispredict kills only entries tagged with the oldest
// branch; branch resolution shifts every mask right by one.
//   clk, rst_n : clock and asynchronous active-low reset
//   rs         : slave side of ooo_reservation_station_if (push, issue,
//                wakeup broadcast, branch_resolved, flush)
// DEPTH must be at least INPUT_PORTS and at least OUTPUT_PORTS.
module ooo_reservation_station
    import ooo_reservation_station_pkg::*;
#(
    parameter int INPUT_PORTS      = 2,
    parameter int OUTPUT_PORTS     = 2,
    parameter int SEARCH_PORTS     = 4,
    parameter int ROB_DEPTH        = RS_ROB_DEPTH,
    parameter int OPERAND_WIDTH    = RS_OPERAND_W,
    parameter int DEPTH            = 8,
    parameter int EXTRA_DATA_WIDTH = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    ooo_reservation_station_if.slave rs
);
    localparam int TAG_W = tag_width(ROB_DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            valid_q, valid_d;
    reservation_entry_t          entry_q [DEPTH];
    reservation_entry_t          entry_d [DEPTH];
    logic [EXTRA_DATA_WIDTH-1:0] extra_q [DEPTH];
    logic [EXTRA_DATA_WIDTH-1:0] extra_d [DEPTH];

    logic [SEARCH_PORTS-1:0]                    s_vld;
    logic [SEARCH_PORTS-1:0][TAG_W-1:0]         s_tag;
    logic [SEARCH_PORTS-1:0][OPERAND_WIDTH-1:0] s_dat;

    logic [CNT_W-1:0]                       occupied, free_cnt;
    logic [INPUT_PORTS-1:0]                 ready_w;
    logic [INPUT_PORTS-1:0][DEPTH-1:0]      alloc;
    logic [DEPTH-1:0]                       avail, req, kill, issue;
    logic [OUTPUT_PORTS-1:0][DEPTH-1:0]     grant;
    logic [OUTPUT_PORTS-1:0]                vout;
    reservation_entry_t [OUTPUT_PORTS-1:0]  dout;
    logic [OUTPUT_PORTS-1:0][EXTRA_DATA_WIDTH-1:0] xout;

    assign s_vld = rs.search_valid;
    assign s_tag = rs.search_tags;
    assign s_dat = rs.search_data;

    // Operand capture from the broadcast buses; scanning high to low lets the
    // lowest matching port index win. Only the entry's own pending bits gate it.
    function automatic reservation_entry_t capture(
        input reservation_entry_t                         e,
        input logic [SEARCH_PORTS-1:0]                    sv,
        input logic [SEARCH_PORTS-1:0][TAG_W-1:0]         st,
        input logic [SEARCH_PORTS-1:0][OPERAND_WIDTH-1:0] sd
    );
        reservation_entry_t r;
        r = e;
        for (int p = SEARCH_PORTS - 1; p >= 0; p--) begin
            if (sv[p] && e.pendingA && st[p] == e.tagA) begin
                r.opA = sd[p];
                r.pendingA = 1'b0;
            end
            if (sv[p] && e.pendingB && st[p] == e.tagB) begin
                r.opB = sd[p];
                r.pendingB = 1'b0;
            end
            if (sv[p] && e.pendingC && st[p] == e.tagC) begin
                r.opC = sd[p];
                r.pendingC = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic reservation_entry_t shift_mask(input reservation_entry_t e,
                                                      input logic br);
        reservation_entry_t r;
        r = e;
        if (br) r.branch_if = e.branch_if >> 1;
        return r;
    endfunction

    // Free space and slot assignment come from registered state only, so a
    // slot released by this cycle's issue becomes reusable next cycle.
    always_comb begin
        occupied = '0;
        for (int k = 0; k < DEPTH; k++) occupied = occupied + CNT_W'(valid_q[k]);
        free_cnt = CNT_W'(DEPTH) - occupied;
        for (int i = 0; i < INPUT_PORTS; i++) begin
            ready_w[i] = (free_cnt > CNT_W'(i)) && !rs.flush;
        end
    end

    // Accepted lanes take successive lowest free slots.
    always_comb begin
        logic placed;
        avail = ~valid_q;
        alloc = '0;
        placed = 1'b0;
        for (int i = 0; i < INPUT_PORTS; i++) begin
            placed = 1'b0;
            if (rs.valid_in[i] && ready_w[i]) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (!placed && avail[k]) begin
                        alloc[i][k] = 1'b1;
                        avail[k] = 1'b0;
                        placed = 1'b1;
                    end
                end
            end
        end
    end

    // Entries on the mispredicted path are masked out of selection in the
    // flush cycle itself, so the next-oldest survivor can take their lane.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            kill[k] = valid_q[k] && rs.flush && entry_q[k].branch_if[0];
            req[k]  = valid_q[k] && !entry_q[k].pendingA && !entry_q[k].pendingB
                      && !entry_q[k].pendingC && !kill[k];
        end
    end

    rs_age_matrix #(
        .DEPTH        (DEPTH),
        .INPUT_PORTS  (INPUT_PORTS),
        .OUTPUT_PORTS (OUTPUT_PORTS)
    ) u_age (
        .clk     (clk),
        .rst_n   (rst_n),
        .alloc   (alloc),
        .dealloc (issue | kill),
        .req     (req),
        .grant   (grant)
    );

    always_comb begin
        issue = '0;
        for (int j = 0; j < OUTPUT_PORTS; j++) begin
            vout[j] = |grant[j];
            dout[j] = '0;
            xout[j] = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if (grant[j][k]) begin
                    dout[j]  = entry_q[k];
                    xout[j]  = extra_q[k];
                    issue[k] = issue[k] | rs.ready_in[j];
                end
            end
        end
    end

    assign rs.ready_out = ready_w;
    assign rs.valid_out = vout;
    assign rs.data_out  = dout;
    assign rs.extra_out = xout;

    // Next state: wakeup and mask shift for residents, then new pushes, which
    // get the same capture and shift applied to their incoming contents.
    always_comb begin
        valid_d = valid_q & ~issue & ~kill;
        for (int k = 0; k < DEPTH; k++) begin
            entry_d[k] = shift_mask(capture(entry_q[k], s_vld, s_tag, s_dat),
                                    rs.branch_resolved);
            extra_d[k] = extra_q[k];
        end
        for (int i = 0; i < INPUT_PORTS; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (alloc[i][k]) begin
                    entry_d[k] = shift_mask(capture(rs.data_in[i], s_vld, s_tag, s_dat),
                                            rs.branch_resolved);
                    extra_d[k] = rs.extra_in[i];
                    valid_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // Payload is qualified by valid_q and needs no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            entry_q[k] <= entry_d[k];
            extra_q[k] <= extra_d[k];
        end
    end

endmodule

// File: tb/tb_ooo_reservation_station.sv
module tb_ooo_reservation_station;
    import ooo_reservation_station_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ooo_reservation_station_if #(
        .INPUT_PORTS(2), .OUTPUT_PORTS(2), .SEARCH_PORTS(4), .EXTRA_DATA_WIDTH(4)
    ) bus ();

    ooo_reservation_station #(
        .INPUT_PORTS(2), .OUTPUT_PORTS(2), .SEARCH_PORTS(4), .ROB_DEPTH(16),
        .OPERAND_WIDTH(32), .DEPTH(8), .EXTRA_DATA_WIDTH(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rs    (bus)
    );

    typedef struct {
        logic [1:0]         vin;
        reservation_entry_t d0;
        reservation_entry_t d1;
        logic [1:0]         rin;
        logic               svld;
        int                 sport;
        logic [3:0]         stag;
        logic [31:0]        sdat;
        logic [1:0]         e_vld;
        reservation_entry_t e_d0;
        reservation_entry_t e_d1;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    // Sideband carried with each entry is the low nibble of opC (its id).
    function automatic reservation_entry_t mk(input logic [3:0] id, input logic [31:0] a,
                                              input logic [3:0] ta, input logic pa,
                                              input logic [3:0] tb, input logic pb,
                                              input logic [3:0] br);
        reservation_entry_t e;
        e = '0;
        e.opA = a;
        e.opB = a + 32'd1;
        e.opC = {28'hC0C0C0C, id};
        e.tagA = ta;
        e.pendingA = pa;
        e.tagB = tb;
        e.pendingB = pb;
        e.branch_if = br;
        return e;
    endfunction

    function automatic vec_t mkv(input logic [1:0] vin, input reservation_entry_t d0,
                                 input reservation_entry_t d1, input logic [1:0] rin,
                                 input logic svld, input int sport, input logic [3:0] stag,
                                 input logic [31:0] sdat, input logic [1:0] e_vld,
                                 input reservation_entry_t e0, input reservation_entry_t e1);
        vec_t v;
        v.vin = vin; v.d0 = d0; v.d1 = d1; v.rin = rin;
        v.svld = svld; v.sport = sport; v.stag = stag; v.sdat = sdat;
        v.e_vld = e_vld; v.e_d0 = e0; v.e_d1 = e1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] vin, input reservation_entry_t d0,
                         input reservation_entry_t d1, input logic [1:0] rin,
                         input logic fl, input logic br);
        bus.valid_in = vin;
        bus.data_in[0] = d0;
        bus.data_in[1] = d1;
        bus.extra_in[0] = d0.opC[3:0];
        bus.extra_in[1] = d1.opC[3:0];
        bus.ready_in = rin;
        bus.flush = fl;
        bus.branch_resolved = br;
        bus.search_valid = '0;
        bus.search_tags = '0;
        bus.search_data = '0;
    endtask

    task automatic bcast(input int port, input logic [3:0] tag, input logic [31:0] dat);
        bus.search_valid[port] = 1'b1;
        bus.search_tags[port] = tag;
        bus.search_data[port] = dat;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] e_rdy, input logic [1:0] e_vld,
                              input reservation_entry_t e0, input reservation_entry_t e1);
        chk({tag, ".ready_out"}, 128'(bus.ready_out), 128'(e_rdy));
        chk({tag, ".valid_out"}, 128'(bus.valid_out), 128'(e_vld));
        chk({tag, ".data_out0"}, 128'(bus.data_out[0]), 128'(e0));
        chk({tag, ".data_out1"}, 128'(bus.data_out[1]), 128'(e1));
        chk({tag, ".extra_out0"}, 128'(bus.extra_out[0]), 128'(e0.opC[3:0]));
        chk({tag, ".extra_out1"}, 128'(bus.extra_out[1]), 128'(e1.opC[3:0]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reservation_entry_t z, e10, e20, p, pw, q, qw, o1, o1w, y1, o2, o2w, y2;
        reservation_entry_t f [8];
        reservation_entry_t k, s, n, zt, k2, k2s, n2, a, as, b, w, ww;
        z = '0;

        e10 = mk(4'd1, 32'h10, 4'd0, 1'b0, 4'd0, 1'b0, 4'b0);
        e20 = mk(4'd2, 32'h20, 4'd0, 1'b0, 4'd0, 1'b0, 4'b0);
        p   = mk(4'd3, 32'h0,  4'd5, 1'b1, 4'd0, 1'b0, 4'b0);
        pw  = p;  pw.opA = 32'hDEADBEEF; pw.pendingA = 1'b0;
        q   = mk(4'd4, 32'h40, 4'd0, 1'b0, 4'd3, 1'b1, 4'b0);
        qw  = q;  qw.opB = 32'hCAFE0003; qw.pendingB = 1'b0;
        o1  = mk(4'd5, 32'h50, 4'd7, 1'b1, 4'd0, 1'b0, 4'b0);
        o1w = o1; o1w.opA = 32'h77; o1w.pendingA = 1'b0;
        y1  = mk(4'd6, 32'h60, 4'd0, 1'b0, 4'd0, 1'b0, 4'b0);
        o2  = mk(4'd7, 32'h70, 4'd9, 1'b1, 4'd0, 1'b0, 4'b0);
        o2w = o2; o2w.opA = 32'h99; o2w.pendingA = 1'b0;
        y2  = mk(4'd8, 32'h80, 4'd0, 1'b0, 4'd0, 1'b0, 4'b0);

        // Cycle-by-cycle vectors; expected outputs are those seen before the edge.
        tbl[0]  = mkv(2'b11, e10, e20, 2'b11, 0, 0, 0, 0,            2'b00, z, z);
        tbl[1]  = mkv(2'b00, z, z,     2'b11, 0, 0, 0, 0,            2'b11, e10, e20);
        tbl[2]  = mkv(2'b00, z, z,     2'b11, 0, 0, 0, 0,            2'b00, z, z);
        tbl[3]  = mkv(2'b01, p, z,     2'b11, 0, 0, 0, 0,            2'b00, z, z);
        tbl[4]  = mkv(2'b00, z, z,     2'b11, 0, 0, 0, 0,            2'b00, z, z);
        tbl[5]  = mkv(2'b00, z, z,     2'b11, 1, 1, 4'd5, 32'hDEADBEEF, 2'b00, z, z);
        tbl[6]  = mkv(2'b00, z, z,     2'b11, 0, 0, 0, 0,            2'b01, pw, z);
        tbl[7]  = mkv(2'b00, z, z,     2'b11, 0, 0, 0, 0,            2'b00, z, z);
        tbl[8]  = mkv(2'b01, q, z,     2'b11, 1, 2, 4'd3, 32'hCAFE0003, 2'b00, z, z);
        tbl[9]  = mkv(2'b00, z, z,     2'b11, 0, 0, 0, 0,            2'b01, qw, z);
        tbl[10] = mkv(2'b00, z, z,     2'b11, 0, 0, 0, 0,            2'b00, z, z);
        tbl[11] = mkv(2'b11, o1, y1,   2'b11, 0, 0, 0, 0,            2'b00, z, z);
        tbl[12] = mkv(2'b00, z, z,     2'b11, 0, 0, 0, 0,            2'b01, y1, z);
        tbl[13] = mkv(2'b00, z, z,     2'b11, 1, 0, 4'd7, 32'h77,    2'b00, z, z);
        tbl[14] = mkv(2'b00, z, z,     2'b11, 0, 0, 0, 0,            2'b01, o1w, z);
        tbl[15] = mkv(2'b11, o2, y2,   2'b00, 0, 0, 0, 0,            2'b00, z, z);
        tbl[16] = mkv(2'b00, z, z,     2'b00, 0, 0, 0, 0,            2'b01, y2, z);
        tbl[17] = mkv(2'b00, z, z,     2'b00, 1, 3, 4'd9, 32'h99,    2'b01, y2, z);
        tbl[18] = mkv(2'b00, z, z,     2'b11, 0, 0, 0, 0,            2'b11, o2w, y2);
        tbl[19] = mkv(2'b00, z, z,     2'b11, 0, 0, 0, 0,            2'b00, z, z);

        // Reset state
        drive(2'b00, z, z, 2'b00, 1'b0, 1'b0);
        @(negedge clk); #1;
        expect_out("reset", 2'b11, 2'b00, z, z);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            drive(tbl[v].vin, tbl[v].d0, tbl[v].d1, tbl[v].rin, 1'b0, 1'b0);
            if (tbl[v].svld) bcast(tbl[v].sport, tbl[v].stag, tbl[v].sdat);
            #1;
            expect_out($sformatf("vec%0d", v), 2'b11, tbl[v].e_vld, tbl[v].e_d0, tbl[v].e_d1);
        end

        // Fill to full, free one slot, hold, then async reset mid-stream.
        for (int i = 0; i < 8; i++) f[i] = mk(4'(i), 32'hF00 + 32'(i), 4'd0, 1'b0, 4'd0, 1'b0, 4'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(2'b11, f[2*c], f[2*c+1], 2'b00, 1'b0, 1'b0);
            #1;
            if (c == 0) expect_out("fill0", 2'b11, 2'b00, z, z);
            else        expect_out($sformatf("fill%0d", c), 2'b11, 2'b11, f[0], f[1]);
        end
        @(negedge clk);
        drive(2'b00, z, z, 2'b01, 1'b0, 1'b0);
        #1;
        expect_out("full", 2'b00, 2'b11, f[0], f[1]);
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            drive(2'b00, z, z, 2'b00, 1'b0, 1'b0);
            #1;
            expect_out($sformatf("hold%0d", h), 2'b01, 2'b11, f[1], f[2]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("reset_mid", 2'b11, 2'b00, z, z);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expect_out("post_reset", 2'b11, 2'b00, z, z);

        // Selective flush; push during flush must be dropped.
        k  = mk(4'd9,  32'h900, 4'd0, 1'b0, 4'd0, 1'b0, 4'b0001);
        s  = mk(4'd10, 32'hA00, 4'd0, 1'b0, 4'd0, 1'b0, 4'b0010);
        n  = mk(4'd11, 32'hB00, 4'd0, 1'b0, 4'd0, 1'b0, 4'b0000);
        zt = mk(4'd12, 32'hC00, 4'd0, 1'b0, 4'd0, 1'b0, 4'b0000);
        @(negedge clk); drive(2'b11, k, s, 2'b00, 1'b0, 1'b0); #1;
        expect_out("fl_push", 2'b11, 2'b00, z, z);
        @(negedge clk); drive(2'b01, n, z, 2'b00, 1'b0, 1'b0); #1;
        expect_out("fl_pre", 2'b11, 2'b11, k, s);
        @(negedge clk); drive(2'b01, zt, z, 2'b11, 1'b1, 1'b0); #1;
        expect_out("fl_cycle", 2'b00, 2'b11, s, n);
        @(negedge clk); drive(2'b00, z, z, 2'b11, 1'b0, 1'b0); #1;
        expect_out("fl_after", 2'b11, 2'b00, z, z);

        // branch_resolved then flush: 0010 becomes 0001 and is killed.
        k2  = mk(4'd13, 32'hD00, 4'd0, 1'b0, 4'd0, 1'b0, 4'b0010);
        n2  = mk(4'd14, 32'hE00, 4'd0, 1'b0, 4'd0, 1'b0, 4'b0000);
        k2s = k2; k2s.branch_if = 4'b0001;
        @(negedge clk); drive(2'b11, k2, n2, 2'b00, 1'b0, 1'b0); #1;
        expect_out("br_push", 2'b11, 2'b00, z, z);
        @(negedge clk); drive(2'b00, z, z, 2'b00, 1'b0, 1'b1); #1;
        expect_out("br_resolve", 2'b11, 2'b11, k2, n2);
        @(negedge clk); drive(2'b00, z, z, 2'b00, 1'b0, 1'b0); #1;
        expect_out("br_shifted", 2'b11, 2'b11, k2s, n2);
        @(negedge clk); drive(2'b00, z, z, 2'b00, 1'b1, 1'b0); #1;
        expect_out("br_flush", 2'b00, 2'b01, n2, z);
        @(negedge clk); drive(2'b00, z, z, 2'b11, 1'b0, 1'b0); #1;
        expect_out("br_survivor", 2'b11, 2'b01, n2, z);
        @(negedge clk); drive(2'b00, z, z, 2'b11, 1'b0, 1'b0); #1;
        expect_out("br_empty", 2'b11, 2'b00, z, z);

        // flush and branch_resolved together: kill on pre-shift mask.
        a  = mk(4'd1, 32'h101, 4'd0, 1'b0, 4'd0, 1'b0, 4'b0010);
        b  = mk(4'd2, 32'h202, 4'd0, 1'b0, 4'd0, 1'b0, 4'b0001);
        as = a; as.branch_if = 4'b0001;
        @(negedge clk); drive(2'b11, a, b, 2'b00, 1'b0, 1'b0); #1;
        expect_out("fb_push", 2'b11, 2'b00, z, z);
        @(negedge clk); drive(2'b00, z, z, 2'b00, 1'b1, 1'b1); #1;
        expect_out("fb_both", 2'b00, 2'b01, a, z);
        @(negedge clk); drive(2'b00, z, z, 2'b00, 1'b0, 1'b0); #1;
        expect_out("fb_after", 2'b11, 2'b01, as, z);
        @(negedge clk); drive(2'b00, z, z, 2'b00, 1'b1, 1'b0); #1;
        expect_out("fb_flush2", 2'b00, 2'b00, z, z);
        @(negedge clk); drive(2'b00, z, z, 2'b00, 1'b0, 1'b0); #1;
        expect_out("fb_empty", 2'b11, 2'b00, z, z);

        // Two ports broadcast the same tag: lowest port index supplies the value.
        w  = mk(4'd3, 32'h303, 4'd6, 1'b1, 4'd0, 1'b0, 4'b0000);
        ww = w; ww.opA = 32'h1111; ww.pendingA = 1'b0;
        @(negedge clk); drive(2'b01, w, z, 2'b11, 1'b0, 1'b0); #1;
        expect_out("mp_push", 2'b11, 2'b00, z, z);
        @(negedge clk); drive(2'b00, z, z, 2'b11, 1'b0, 1'b0);
        bcast(3, 4'd6, 32'h3333);
        bcast(1, 4'd6, 32'h1111);
        #1;
        expect_out("mp_bcast", 2'b11, 2'b00, z, z);
        @(negedge clk); drive(2'b00, z, z, 2'b11, 1'b0, 1'b0); #1;
        expect_out("mp_issue", 2'b11, 2'b01, ww, z);
        @(negedge clk); drive(2'b00, z, z, 2'b11, 1'b0, 1'b0); #1;
        expect_out("mp_empty", 2'b11, 2'b00, z, z);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
